// File: rtl/fifo_burst_reader_if.sv
// FIFO read-side and output stream bundle for fifo_burst_reader.
// A beat transfers on a rising edge where m_valid & m_ready; m_data/m_last hold while m_valid & ~m_ready.
interface fifo_burst_reader_if #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 4
);
    logic [DATA_WIDTH-1:0] fifo_rd_data;
    logic                  fifo_empty;
    logic [ADDR_WIDTH:0]   fifo_count;
    logic                  fifo_rd_en;
    logic [DATA_WIDTH-1:0] m_data;
    logic                  m_valid;
    logic                  m_last;
    logic                  m_ready;

    modport master (
        input  fifo_rd_data, fifo_empty, fifo_count, m_ready,
        output fifo_rd_en, m_data, m_valid, m_last
    );

    modport slave (
        output fifo_rd_data, fifo_empty, fifo_count, m_ready,
        input  fifo_rd_en, m_data, m_valid, m_last
    );
endinterface

// File: rtl/fifo_burst_reader.sv
// Drains a first-word fall-through FIFO in fixed-length bursts onto a valid/ready stream,
// releasing short bursts on timeout or flush so no data strands in the FIFO.
module fifo_burst_reader #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 4,
    parameter int BURST_LEN  = 4,
    parameter int TIMEOUT    = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    fifo_burst_reader_if.master  bus,
    input  logic                 flush,
    output logic                 busy,
    output logic [15:0]          burst_count,
    output logic [1:0]           dbg_state
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        LAST  = 2'd2
    } state_t;

    localparam int              CW          = ADDR_WIDTH + 1;
    localparam logic [CW-1:0]   BURST_BEATS = CW'(BURST_LEN);
    localparam bit              TIMEOUT_EN  = (TIMEOUT != 0);
    localparam logic [15:0]     TIMEOUT_LIM = TIMEOUT_EN ? 16'(TIMEOUT - 1) : 16'd0;

    state_t                state_q, state_d;
    logic [CW-1:0]         beats_q;
    logic [15:0]           timer_q;
    logic                  flush_q;
    logic [DATA_WIDTH-1:0] head;
    logic                  has_data, full, short_due;
    logic                  go, pop, done;

    assign head      = bus.fifo_rd_data;
    assign has_data  = (bus.fifo_count != '0);
    assign full      = (bus.fifo_count >= BURST_BEATS);
    assign short_due = has_data && (flush_q || (TIMEOUT_EN && (timer_q >= TIMEOUT_LIM)));

    always_comb begin
        state_d = state_q;
        go      = 1'b0;
        pop     = 1'b0;
        done    = 1'b0;
        case (state_q)
            IDLE: begin
                if (full || short_due) begin
                    go      = 1'b1;
                    state_d = BURST;
                end
            end
            BURST: begin
                pop = (beats_q != '0) && !bus.fifo_empty && (!bus.m_valid || bus.m_ready);
                if (pop && (beats_q == CW'(1))) begin
                    state_d = LAST;
                end
            end
            LAST: begin
                if (bus.m_valid && bus.m_ready) begin
                    done    = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.fifo_rd_en = pop;
    assign busy           = (state_q != IDLE);
    assign dbg_state      = state_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            beats_q     <= '0;
            timer_q     <= '0;
            flush_q     <= 1'b0;
            bus.m_data  <= '0;
            bus.m_valid <= 1'b0;
            bus.m_last  <= 1'b0;
            burst_count <= '0;
        end else begin
            state_q <= state_d;
            // A new flush request wins over consumption of an older one in the same cycle.
            flush_q <= flush || (flush_q && !((state_q == IDLE) && (!has_data || go)));

            if ((state_q == IDLE) && has_data && !full && !go) begin
                if (timer_q != 16'hFFFF) begin
                    timer_q <= timer_q + 16'd1;
                end
            end else begin
                timer_q <= '0;
            end

            if (go) begin
                beats_q <= full ? BURST_BEATS : bus.fifo_count;
            end else if (pop) begin
                beats_q <= beats_q - CW'(1);
            end

            if (pop) begin
                bus.m_data  <= head;
                bus.m_valid <= 1'b1;
                bus.m_last  <= (beats_q == CW'(1));
            end else if (bus.m_valid && bus.m_ready) begin
                bus.m_valid <= 1'b0;
                bus.m_last  <= 1'b0;
            end

            if (done) begin
                burst_count <= burst_count + 16'd1;
            end
        end
    end
endmodule

// File: tb/tb_fifo_burst_reader.sv
// Bench for fifo_burst_reader: FIFO model, scoreboard on the output stream, vector table plus corner sequences.
module tb_fifo_burst_reader;
    localparam int DW = 16;
    localparam int AW = 4;
    localparam int BL = 4;
    localparam int TO = 64;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fifo_burst_reader_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();
    fifo_burst_reader_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus16 ();

    logic        flush = 1'b0;
    logic        busy, busy16;
    logic [15:0] burst_count, burst_count16;
    logic [1:0]  dbg_state, dbg_state16;

    fifo_burst_reader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BURST_LEN(BL), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .bus(bus), .flush(flush),
        .busy(busy), .burst_count(burst_count), .dbg_state(dbg_state)
    );

    fifo_burst_reader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BURST_LEN(16), .TIMEOUT(TO)) dut16 (
        .clk(clk), .rst(rst), .bus(bus16), .flush(1'b0),
        .busy(busy16), .burst_count(burst_count16), .dbg_state(dbg_state16)
    );

    // FIFO models: occupancy is write pointer minus read pointer
    logic [DW-1:0] mem [16];
    int wr_ptr = 0;
    int rd_ptr = 0;
    int wr16   = 0;
    int rd16   = 0;

    assign bus.fifo_count     = 5'(wr_ptr - rd_ptr);
    assign bus.fifo_empty     = (wr_ptr == rd_ptr);
    assign bus.fifo_rd_data   = mem[rd_ptr[3:0]];
    assign bus16.fifo_count   = 5'(wr16 - rd16);
    assign bus16.fifo_empty   = (wr16 == rd16);
    assign bus16.fifo_rd_data = 16'h0200 + 16'(rd16);
    assign bus16.m_ready      = 1'b1;

    always @(posedge clk) begin
        if (bus.fifo_rd_en) rd_ptr <= rd_ptr + 1;
        if (bus16.fifo_rd_en) rd16 <= rd16 + 1;
    end

    int         ready_mode = 0;
    int         cyc = 0;
    logic [3:0] pat = 4'b1001;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        #1;
        case (ready_mode)
            0:       bus.m_ready = 1'b1;
            1:       bus.m_ready = pat[2'(cyc % 4)];
            default: bus.m_ready = 1'($urandom_range(0, 1));
        endcase
    end

    int checks = 0;
    int errors = 0;
    int acc_cnt = 0;
    logic [DW:0] exp_q[$];

    logic          stall_q = 1'b0;
    logic [DW-1:0] hold_data;
    logic          hold_last;
    logic [DW:0]   exp_beat;

    always @(negedge clk) begin
        if (rst) begin
            stall_q = 1'b0;
        end else begin
            if (stall_q) begin
                checks++;
                if (!bus.m_valid || bus.m_data !== hold_data || bus.m_last !== hold_last) begin
                    errors++;
                    $display("FAIL stall_hold actual v=%0b d=%0h l=%0b required v=1 d=%0h l=%0b",
                             bus.m_valid, bus.m_data, bus.m_last, hold_data, hold_last);
                end
            end
            stall_q   = bus.m_valid && !bus.m_ready;
            hold_data = bus.m_data;
            hold_last = bus.m_last;

            checks++;
            if (bus.fifo_rd_en && ((bus.m_valid && !bus.m_ready) || bus.fifo_empty || dbg_state == 2'd0)) begin
                errors++;
                $display("FAIL pop_rule actual rd_en=1 v=%0b r=%0b empty=%0b state=%0d required rd_en=0",
                         bus.m_valid, bus.m_ready, bus.fifo_empty, dbg_state);
            end

            if (bus.m_valid && bus.m_ready) begin
                checks++;
                acc_cnt++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL beat actual d=%0h l=%0b required no beat", bus.m_data, bus.m_last);
                end else begin
                    exp_beat = exp_q.pop_front();
                    if ({bus.m_last, bus.m_data} !== exp_beat) begin
                        errors++;
                        $display("FAIL beat actual d=%0h l=%0b required d=%0h l=%0b",
                                 bus.m_data, bus.m_last, exp_beat[DW-1:0], exp_beat[DW]);
                    end
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %0h required %0h", name, act, exp);
        end
    endtask

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    // Words land in an empty FIFO at once, so bursts split as BL-beat groups plus a remainder
    task automatic write_words(input int n, input logic [DW-1:0] base);
        for (int i = 0; i < n; i++) begin
            mem[wr_ptr[3:0]] = base + 16'(i);
            exp_q.push_back({1'((i % 4 == 3) || (i == n - 1)), base + 16'(i)});
            wr_ptr++;
        end
    endtask

    task automatic wait_gap(output int gap);
        int n;
        n = 0;
        gap = -1;
        while (n < 300) begin
            @(negedge clk);
            if (bus.fifo_rd_en) begin
                gap = n;
                break;
            end
            n++;
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            #1;
            n++;
        end while (!(dbg_state == 2'd0 && bus.fifo_empty && exp_q.size() == 0 && !bus.m_valid) && n < 500);
        check("drain_done", 32'(n < 500), 32'd1);
    endtask

    typedef struct {
        int n_words;
        bit do_flush;
        int ready_mode;
        int exp_bursts;
    } vec_t;

    vec_t vecs[7];

    initial begin
        int g;
        int exp_bc;
        int start;
        int n;
        int remaining;
        int beats;
        logic [11:0] pops;

        vecs[0] = '{8, 1'b0, 0, 2};
        vecs[1] = '{3, 1'b1, 0, 1};
        vecs[2] = '{6, 1'b0, 1, 2};
        vecs[3] = '{16, 1'b0, 2, 4};
        vecs[4] = '{5, 1'b1, 1, 2};
        vecs[5] = '{4, 1'b0, 2, 1};
        vecs[6] = '{1, 1'b1, 2, 1};
        exp_bc = 0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_m_valid", 32'(bus.m_valid), 32'd0);
        check("rst_m_last", 32'(bus.m_last), 32'd0);
        check("rst_m_data", 32'(bus.m_data), 32'd0);
        check("rst_rd_en", 32'(bus.fifo_rd_en), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_burst_count", 32'(burst_count), 32'd0);
        check("rst_state", 32'(dbg_state), 32'd0);
        rst = 1'b0;
        sync();

        // Two back-to-back full bursts: pops 4 per burst, starts BL+2 cycles apart
        write_words(8, 16'h0010);
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            pops[i] = bus.fifo_rd_en;
        end
        check("throughput_pops", 32'(pops), 32'h79E);
        wait_idle();
        exp_bc += 2;
        check("throughput_bursts", 32'(burst_count), 32'(exp_bc));

        sync();
        write_words(3, 16'h0030);
        wait_gap(g);
        check("timeout_gap", 32'(g), 32'(TO));
        wait_idle();
        exp_bc += 1;
        check("timeout_bursts", 32'(burst_count), 32'(exp_bc));

        sync();
        write_words(2, 16'h0040);
        flush = 1'b1;
        sync();
        flush = 1'b0;
        wait_gap(g);
        check("flush_gap", 32'(g), 32'd1);
        wait_idle();
        exp_bc += 1;
        check("flush_bursts", 32'(burst_count), 32'(exp_bc));

        // Flush with nothing stored must leave no pending request behind
        sync();
        flush = 1'b1;
        sync();
        flush = 1'b0;
        repeat (5) sync();
        check("zero_flush_valid", 32'(bus.m_valid), 32'd0);
        check("zero_flush_busy", 32'(busy), 32'd0);
        write_words(2, 16'h0050);
        wait_gap(g);
        check("zero_flush_gap", 32'(g), 32'(TO));
        wait_idle();
        exp_bc += 1;
        check("zero_flush_bursts", 32'(burst_count), 32'(exp_bc));

        for (int k = 0; k < 7; k++) begin
            ready_mode = vecs[k].ready_mode;
            sync();
            write_words(vecs[k].n_words, 16'(256 + 32 * k));
            if (vecs[k].do_flush) begin
                flush = 1'b1;
                sync();
                flush = 1'b0;
            end
            wait_idle();
            exp_bc += vecs[k].exp_bursts;
            check("vec_bursts", 32'(burst_count), 32'(exp_bc));
            check("vec_busy", 32'(busy), 32'd0);
        end

        // Reset while two beats of a four-beat burst have gone out
        ready_mode = 0;
        sync();
        write_words(4, 16'h0600);
        start = acc_cnt;
        n = 0;
        while (acc_cnt < start + 2 && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("rst_wait", 32'(acc_cnt >= start + 2), 32'd1);
        rst = 1'b1;
        #1;
        check("mid_rst_m_valid", 32'(bus.m_valid), 32'd0);
        check("mid_rst_m_last", 32'(bus.m_last), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_rd_en", 32'(bus.fifo_rd_en), 32'd0);
        check("mid_rst_state", 32'(dbg_state), 32'd0);
        remaining = wr_ptr - rd_ptr;
        check("mid_rst_remaining", 32'(remaining), 32'd2);
        while (exp_q.size() > remaining) void'(exp_q.pop_front());
        for (int i = 0; i < exp_q.size(); i++) exp_q[i][DW] = (i == exp_q.size() - 1);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        exp_bc = 0;
        check("post_rst_burst_count", 32'(burst_count), 32'd0);
        wait_idle();
        exp_bc += 1;
        check("post_rst_bursts", 32'(burst_count), 32'(exp_bc));

        // Full 16-deep FIFO against a 16-beat burst: count is 5'b10000
        sync();
        wr16 = 16;
        beats = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (bus16.m_valid) begin
                check("b16_data", 32'(bus16.m_data), 32'(16'h0200 + 16'(beats)));
                check("b16_last", 32'(bus16.m_last), 32'(beats == 15));
                beats++;
            end
        end
        check("b16_beats", 32'(beats), 32'd16);
        check("b16_bursts", 32'(burst_count16), 32'd1);
        check("b16_busy", 32'(busy16), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
